shared_bus_ctrl: RTL and testbench

Downstream consumer of the two-client round-robin arbiter (`arb`). Collects single-word read/write commands from clients A and B, presents their requests to `arb`, and latches the winning client's command. Runs one transaction on a shared memory port with a valid/ready handshake, then returns the result with a 4-phase req/ack handshake. A timeout counter aborts stuck memory transactions.

---
 rtl/shared_bus_ctrl_pkg.sv | 13 +
 rtl/shared_bus_ctrl.sv | 153 +++++++++++++++
 tb/tb_shared_bus_ctrl.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/shared_bus_ctrl_pkg.sv
// Shared encodings for the shared memory bus controller.
package shared_bus_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  localparam logic OWN_A = 1'b0;
  localparam logic OWN_B = 1'b1;

endpackage

// File: rtl/shared_bus_ctrl.sv
// Two-client shared memory port controller.
// Consumes grants from an external round-robin arbiter, runs one memory
// transaction with a valid/ready handshake and returns the result to the
// winning client over a 4-phase req/ack handshake.
//
//   state  | meaning
//   -------+----------------------------------------------------------
//   IDLE   | arbiter requests forwarded; a grant latches that client
//   REQ    | command presented on mem_*; waiting for mem_ready/timeout
//   ACK    | owner's ack high with result; waiting for owner req to drop
module shared_bus_ctrl
  import shared_bus_ctrl_pkg::*;
#(
  parameter int AW      = 8,
  parameter int DW      = 16,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_ack,
  output logic          a_err,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_ack,
  output logic          b_err,
  output logic [DW-1:0] b_rdata,
  output logic          arb_req_a,
  output logic          arb_req_b,
  input  logic          arb_grant_a,
  input  logic          arb_grant_b,
  output logic          mem_valid,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_rdata
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  state_t          r_state;
  logic            r_owner;
  logic [CW-1:0]   r_cnt;
  logic            r_we;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata;
  logic            r_a_ack, r_a_err, r_b_ack, r_b_err;
  logic [DW-1:0]   r_a_rdata, r_b_rdata;

  logic            w_owner_req;
  logic            w_timeout;
  logic            w_err;
  logic [DW-1:0]   w_rdata;

  // Result to hand back on leaving REQ: ready wins over a coincident timeout.
  assign w_owner_req = (r_owner == OWN_A) ? a_req : b_req;
  assign w_timeout   = (TIMEOUT != 0) && (r_cnt == CNT_LAST);
  assign w_err       = !mem_ready;
  assign w_rdata     = mem_ready ? mem_rdata : '0;

  // Arbiter only sees requests in IDLE so it advances on real arbitrations.
  assign arb_req_a = (r_state == S_IDLE) && a_req;
  assign arb_req_b = (r_state == S_IDLE) && b_req;

  assign mem_valid = (r_state == S_REQ);
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

  assign a_ack   = r_a_ack;
  assign a_err   = r_a_err;
  assign a_rdata = r_a_rdata;
  assign b_ack   = r_b_ack;
  assign b_err   = r_b_err;
  assign b_rdata = r_b_rdata;

  // Controller FSM with command register, timeout counter and client results.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_owner   <= OWN_A;
      r_cnt     <= '0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_a_ack   <= 1'b0;
      r_a_err   <= 1'b0;
      r_a_rdata <= '0;
      r_b_ack   <= 1'b0;
      r_b_err   <= 1'b0;
      r_b_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // A takes precedence if the arbiter ever grants both.
          if (arb_grant_a) begin
            r_owner <= OWN_A;
            r_we    <= a_we;
            r_addr  <= a_addr;
            r_wdata <= a_wdata;
            r_cnt   <= '0;
            r_state <= S_REQ;
          end else if (arb_grant_b) begin
            r_owner <= OWN_B;
            r_we    <= b_we;
            r_addr  <= b_addr;
            r_wdata <= b_wdata;
            r_cnt   <= '0;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          if (mem_ready || w_timeout) begin
            if (r_owner == OWN_A) begin
              r_a_ack   <= 1'b1;
              r_a_err   <= w_err;
              r_a_rdata <= w_rdata;
            end else begin
              r_b_ack   <= 1'b1;
              r_b_err   <= w_err;
              r_b_rdata <= w_rdata;
            end
            r_state <= S_ACK;
          end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_ACK: begin
          if (!w_owner_req) begin
            r_a_ack   <= 1'b0;
            r_a_err   <= 1'b0;
            r_a_rdata <= '0;
            r_b_ack   <= 1'b0;
            r_b_err   <= 1'b0;
            r_b_rdata <= '0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shared_bus_ctrl.sv
// Bench for shared_bus_ctrl with a round-robin arbiter model and a memory
// model whose ready delay is programmable (255 = never ready).
module tb_shared_bus_ctrl;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int TIMEOUT = 15;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_wdata = '0, b_wdata = '0;
  logic          a_ack, a_err, b_ack, b_err;
  logic [DW-1:0] a_rdata, b_rdata;
  logic          arb_req_a, arb_req_b, arb_grant_a, arb_grant_b;
  logic          mem_valid, mem_we, mem_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  shared_bus_ctrl #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_err(a_err), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_err(b_err), .b_rdata(b_rdata),
    .arb_req_a(arb_req_a), .arb_req_b(arb_req_b),
    .arb_grant_a(arb_grant_a), .arb_grant_b(arb_grant_b),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  // Round-robin arbiter model; after reset B holds priority.
  logic r_last_b;
  assign arb_grant_a = arb_req_a && (!arb_req_b || r_last_b);
  assign arb_grant_b = arb_req_b && (!arb_req_a || !r_last_b);
  always @(posedge clk) begin
    if (reset) r_last_b <= 1'b0;
    else if (arb_grant_a) r_last_b <= 1'b0;
    else if (arb_grant_b) r_last_b <= 1'b1;
  end

  // Memory model.
  int            mem_delay = 0;
  logic [DW-1:0] mem_data = '0;
  logic [7:0]    mem_wcnt;
  logic [24:0]   mem_log[$];
  assign mem_ready = mem_valid && (mem_delay != 255) && (int'(mem_wcnt) == mem_delay);
  assign mem_rdata = mem_ready ? mem_data : 16'hDEAD;
  always @(posedge clk) begin
    if (reset || !mem_valid || mem_ready) mem_wcnt <= '0;
    else mem_wcnt <= mem_wcnt + 8'd1;
    if (!reset && mem_valid && mem_ready) mem_log.push_back({mem_we, mem_addr, mem_wdata});
  end

  // Monitors: illegal double grant, command changing while valid.
  int          illegal = 0;
  int          unstable = 0;
  logic        r_pv = 1'b0;
  logic [24:0] r_pc = '0;
  always @(posedge clk) if (arb_grant_a && arb_grant_b) illegal <= illegal + 1;
  always @(negedge clk) begin
    if (mem_valid && r_pv && ({mem_we, mem_addr, mem_wdata} != r_pc)) unstable <= unstable + 1;
    r_pv <= mem_valid;
    r_pc <= {mem_we, mem_addr, mem_wdata};
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [31:0] all_outs();
    return {16'(a_ack + a_err + b_ack + b_err + arb_req_a + arb_req_b + mem_valid + mem_we),
            16'(a_rdata | b_rdata | mem_wdata | {8'h00, mem_addr})};
  endfunction

  typedef struct {
    logic          is_b;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] mdata;
    int            delay;
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
    int            exp_lat;
    int            exp_vcyc;
  } vec_t;

  task automatic run_vec(input vec_t v, input string nm);
    int  lat;
    int  vcyc;
    bit  got;
    logic ack, err, oack;
    logic [DW-1:0] rd;
    mem_delay = v.delay;
    mem_data  = v.mdata;
    lat = 0; vcyc = 0; got = 0;
    if (v.is_b) begin b_we = v.we; b_addr = v.addr; b_wdata = v.wdata; b_req = 1'b1; end
    else        begin a_we = v.we; a_addr = v.addr; a_wdata = v.wdata; a_req = 1'b1; end
    while (!got && lat < 60) begin
      @(negedge clk);
      lat++;
      if (mem_valid) vcyc++;
      if (lat == 1) begin
        chk({nm, " mem_valid"}, 32'(mem_valid), 32'd1);
        chk({nm, " mem_cmd"}, 32'({mem_we, mem_addr, mem_wdata}), 32'({v.we, v.addr, v.wdata}));
      end
      if (v.is_b ? b_ack : a_ack) got = 1;
    end
    ack  = v.is_b ? b_ack : a_ack;
    err  = v.is_b ? b_err : a_err;
    rd   = v.is_b ? b_rdata : a_rdata;
    oack = v.is_b ? a_ack : b_ack;
    chk({nm, " latency"}, 32'(lat), 32'(v.exp_lat));
    chk({nm, " valid_cycles"}, 32'(vcyc), 32'(v.exp_vcyc));
    chk({nm, " rdata"}, 32'(rd), 32'(v.exp_rdata));
    chk({nm, " err"}, 32'(err), 32'(v.exp_err));
    chk({nm, " other_ack"}, 32'(oack), 32'd0);
    @(negedge clk);
    chk({nm, " ack_held"}, 32'(v.is_b ? b_ack : a_ack), 32'd1);
    if (v.is_b) b_req = 1'b0; else a_req = 1'b0;
    @(negedge clk);
    chk({nm, " ack_drop"}, 32'(v.is_b ? b_ack : a_ack), 32'(1'b0 & ack));
    chk({nm, " rdata_drop"}, 32'(v.is_b ? b_rdata : a_rdata), 32'd0);
  endtask

  vec_t vecs[5];
  int   a_done, b_done, viol;
  bit   seen;

  initial begin
    vecs[0] = '{1'b0, 1'b0, 8'h10, 16'h0000, 16'h1234, 0,   16'h1234, 1'b0, 2,  1};
    vecs[1] = '{1'b1, 1'b1, 8'h20, 16'h5A5A, 16'h0F0F, 5,   16'h0F0F, 1'b0, 7,  6};
    vecs[2] = '{1'b0, 1'b0, 8'h33, 16'h0001, 16'hCAFE, 255, 16'h0000, 1'b1, 16, 15};
    vecs[3] = '{1'b0, 1'b1, 8'h44, 16'h1111, 16'hBEEF, 1,   16'hBEEF, 1'b0, 3,  2};
    vecs[4] = '{1'b1, 1'b0, 8'hFF, 16'h2222, 16'hFFFF, 0,   16'hFFFF, 1'b0, 2,  1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", all_outs(), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_outputs", all_outs(), 32'd0);

    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Both clients stream writes: after reset service alternates B, A, B, A.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mem_log.delete();
    mem_delay = 0;
    a_we = 1'b1; a_addr = 8'h01; a_wdata = 16'hAAAA;
    b_we = 1'b1; b_addr = 8'h02; b_wdata = 16'hBBBB;
    a_done = 0; b_done = 0;
    a_req = 1'b1; b_req = 1'b1;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      if (a_ack && a_req) begin a_req = 1'b0; a_done++; end
      else if (!a_ack && !a_req && a_done < 2) a_req = 1'b1;
      if (b_ack && b_req) begin b_req = 1'b0; b_done++; end
      else if (!b_ack && !b_req && b_done < 2) b_req = 1'b1;
      if (a_done == 2 && b_done == 2 && !a_ack && !b_ack) break;
    end
    chk("rr_a_done", 32'(a_done), 32'd2);
    chk("rr_b_done", 32'(b_done), 32'd2);
    chk("rr_count", 32'(mem_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      logic [24:0] e;
      e = (i % 2 == 0) ? {1'b1, 8'h02, 16'hBBBB} : {1'b1, 8'h01, 16'hAAAA};
      chk($sformatf("rr_order%0d", i), 32'(i < mem_log.size() ? mem_log[i] : 25'h0), 32'(e));
    end

    // Reset while in REQ abandons the transaction.
    mem_delay = 255;
    a_we = 1'b0; a_addr = 8'h55; a_wdata = 16'h0000;
    a_req = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_req_valid", 32'(mem_valid), 32'd1);
    reset = 1'b1;
    a_req = 1'b0;
    @(negedge clk);
    chk("rst_mid_outputs", all_outs(), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_after_outputs", all_outs(), 32'd0);
    run_vec(vecs[0], "post_rst");

    // B requests while A is in REQ: held off until IDLE, then served.
    mem_delay = 3;
    mem_data  = 16'h6666;
    a_we = 1'b0; a_addr = 8'h66;
    b_we = 1'b1; b_addr = 8'h77; b_wdata = 16'h7777;
    a_req = 1'b1;
    viol = 0; seen = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (cyc == 1) b_req = 1'b1;
      if ((mem_valid || a_ack) && arb_req_b) viol++;
      if (a_ack) begin seen = 1; a_req = 1'b0; end
      else if (seen) break;
    end
    chk("hold_seen_a_ack", 32'(seen), 32'd1);
    chk("hold_arb_req_b_low", 32'(viol), 32'd0);
    chk("hold_arb_req_b_idle", 32'(arb_req_b), 32'd1);
    seen = 0;
    for (int cyc = 0; cyc < 40 && !seen; cyc++) begin
      @(negedge clk);
      if (b_ack) seen = 1;
    end
    chk("hold_b_ack", 32'(seen), 32'd1);
    chk("hold_b_rdata", 32'(b_rdata), 32'h6666);
    chk("hold_b_err", 32'(b_err), 32'd0);
    chk("hold_b_log", 32'(mem_log.size() > 0 ? mem_log[mem_log.size()-1] : 25'h0),
        32'({1'b1, 8'h77, 16'h7777}));
    b_req = 1'b0;
    @(negedge clk);
    chk("hold_b_ack_drop", 32'(b_ack), 32'd0);

    chk("double_grant", 32'(illegal), 32'd0);
    chk("cmd_stable", 32'(unstable), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
